vec_mem_seq: RTL and testbench
==============================

Name: vec_mem_seq

Overview:
- Vector load/store sequencer between the CVP14 vector register file (VRF) and the DRAM port (Addr/RD/WR/DataIn/DataOut).
- On a one-cycle Start, streams one VLEN-element vector between memory and a VRF register.
- Each element is one 16-bit word; consecutive element addresses are separated by a programmable stride.
- Issues one memory access per cycle, fully pipelined against the fixed DRAM read latency.

Parameters:
- VLEN, 16, elements per vector. Power of two, 2..16.
- RD_LAT, 1, cycles from RD asserted (with Addr) to valid DataIn. Range 1..4.

Ports:
- Clk1 input 1: sole clock, rising-edge.
- Reset input 1: synchronous, active-high.
- Start input 1: command strobe; sampled only while Busy=0.
- IsStore input 1: 1=store (VRF to memory), 0=load (memory to VRF). Sampled with Start.
- BaseAddr input 16: address of element 0. Sampled with Start.
- Stride input 16: element address increment, two's complement. Sampled with Start.
- Addr output 16: memory word address.
- RD output 1: memory read strobe.
- WR output 1: memory write strobe.
- DataOut output 16: memory write data.
- DataIn input 16: memory read data.
- VecIdx output 4: VRF element index for the current store read.
- VecRdData input 16: VRF element data, combinational from VecIdx.
- VecWrEn output 1: VRF element write enable.
- VecWrIdx output 4: VRF element write index.
- VecWrData output 16: VRF element write data.
- Busy output 1: command in progress.
- Done output 1: one-cycle completion pulse.

Behaviour:
- Reset (synchronous, dominant over all other inputs): state=IDLE. Addr=0, RD=0, WR=0, DataOut=0, VecIdx=0, VecWrEn=0, VecWrIdx=0, VecWrData=0, Busy=0, Done=0. In-flight reads are discarded. VRF elements already written stay written.
- States: IDLE, LOAD, DRAIN, STORE, FIN.
- IDLE: Start=1 latches IsStore, BaseAddr and Stride; clears element counter i and address accumulator A=BaseAddr. Next state is STORE if IsStore=1, else LOAD. Busy=1 from the next cycle.
- Start while Busy=1: ignored, no queuing.
- LOAD, cycles 1..VLEN after Start:
  - RD=1, Addr=A, A<=A+Stride, i<=i+1.
  - After the i=VLEN-1 issue, go to DRAIN.
- Load return path:
  - A RD issued in cycle c produces VecWrEn=1 in cycle c+RD_LAT, with VecWrData=DataIn and VecWrIdx equal to that element's index.
  - The return path is an RD_LAT-deep shift of {valid, idx}. Element writes occur in cycles 1+RD_LAT .. VLEN+RD_LAT.
- DRAIN: RD=0. Stays in DRAIN until the last element write has occurred, then goes to FIN.
- STORE, cycles 1..VLEN after Start:
  - VecIdx=i, WR=1, Addr=A, DataOut=VecRdData (same cycle), A<=A+Stride, i<=i+1.
  - After i=VLEN-1, go to FIN.
  - RD=0 and VecWrEn=0 throughout.
- FIN: Done=1 and Busy=0 for exactly one cycle, then IDLE.
  - Load: Done in cycle VLEN+RD_LAT+1. Store: Done in cycle VLEN+1.
  - Start in the FIN cycle is ignored. Start is accepted in the IDLE cycle that follows.
- Address arithmetic is 16-bit modulo 2^16: wrap-around past 0xFFFF or below 0x0000 is silent. Stride=0 repeats the same address.
- RD and WR are never both 1. When idle, Addr holds its last value while RD=WR=0.
- Reset during LOAD, DRAIN or STORE: next cycle is IDLE with all outputs at reset values. No Done is produced for the aborted command.

Test Plan:
- Reset: hold Reset 2 cycles mid-store (after 5 WRs) -> next cycle RD=WR=VecWrEn=Busy=Done=0; no Done follows; a new Start is accepted normally.
- Unit-stride load: memory[0x0100+k]=0xA000+k, Start with IsStore=0, BaseAddr=0x0100, Stride=1, RD_LAT=1 -> RD high cycles 1..16, Addr 0x0100..0x010F; VecWrEn cycles 2..17 writing idx k=0xA000+k; Done only in cycle 18.
- Strided store with wrap: VRF[k]=0x5500+k, Start with IsStore=1, BaseAddr=0xFFFC, Stride=2 -> WR cycles 1..16 at Addr 0xFFFC, 0xFFFE, 0x0000, ..., 0x001A with DataOut=0x5500+k; Done in cycle 17; memory readback matches.
- Negative and zero stride: load with BaseAddr=0x0040, Stride=0xFFFF -> Addr 0x0040 down to 0x0031. Store with Stride=0 -> 16 WRs to the same address; final memory value is 0x550F.
- Latency sweep: RD_LAT=3 load -> VecWrEn cycles 4..19 in order with indices 0..15; Done in cycle 20; RD never overlaps WR.
- Start collision: pulse Start at cycle 5 of a load and in the FIN cycle -> both ignored. Start in the following IDLE cycle begins a new command; exactly one Done per accepted command.

Source files
------------

// File: rtl/vec_mem_seq.sv
`default_nettype none
// ============================================================================
//  Module      : vec_mem_seq
//  Description : Vector load/store sequencer between the vector register file
//                and the DRAM word port. A one-cycle Start moves one VLEN-
//                element vector, one 16-bit element per cycle, with a
//                programmable two's-complement address stride. Loads are fully
//                pipelined against a fixed RD_LAT read latency.
//  Ports       : Clk1/Reset       - clock, synchronous active-high reset
//                Start/IsStore/BaseAddr/Stride - command, sampled when idle
//                Addr/RD/WR/DataOut/DataIn     - memory word port
//                VecIdx/VecRdData              - VRF read (store source)
//                VecWrEn/VecWrIdx/VecWrData    - VRF write (load sink)
//                Busy/Done                     - status, Done is a 1-cycle pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module vec_mem_seq #(
    parameter int VLEN   = 16,
    parameter int RD_LAT = 1
) (
    input  logic        Clk1,
    input  logic        Reset,
    input  logic        Start,
    input  logic        IsStore,
    input  logic [15:0] BaseAddr,
    input  logic [15:0] Stride,
    output logic [15:0] Addr,
    output logic        RD,
    output logic        WR,
    output logic [15:0] DataOut,
    input  logic [15:0] DataIn,
    output logic [3:0]  VecIdx,
    input  logic [15:0] VecRdData,
    output logic        VecWrEn,
    output logic [3:0]  VecWrIdx,
    output logic [15:0] VecWrData,
    output logic        Busy,
    output logic        Done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_STORE = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    localparam logic [3:0] C_LAST_IDX = 4'(VLEN - 1);

    logic [2:0]  r_state_q,  w_state_d;
    logic [15:0] r_acc_q,    w_acc_d;     // address of the next element
    logic [15:0] r_stride_q, w_stride_d;
    logic [3:0]  r_idx_q,    w_idx_d;     // index of the next element
    logic [15:0] r_hold_q,   w_hold_d;    // last issued address, shown while idle

    // Read return path: one {valid, idx} slot per cycle of read latency.
    logic [RD_LAT-1:0]      r_pipe_vld_q, w_pipe_vld_d;
    logic [RD_LAT-1:0][3:0] r_pipe_idx_q, w_pipe_idx_d;

    logic w_issue;
    logic w_ret_vld;
    logic [3:0] w_ret_idx;

    assign w_issue   = (r_state_q == S_LOAD) || (r_state_q == S_STORE);
    assign w_ret_vld = r_pipe_vld_q[RD_LAT-1];
    assign w_ret_idx = r_pipe_idx_q[RD_LAT-1];

    always_comb begin
        w_state_d  = r_state_q;
        w_acc_d    = r_acc_q;
        w_stride_d = r_stride_q;
        w_idx_d    = r_idx_q;
        w_hold_d   = r_hold_q;

        case (r_state_q)
            S_IDLE: begin
                if (Start) begin
                    w_acc_d    = BaseAddr;
                    w_stride_d = Stride;
                    w_idx_d    = 4'd0;
                    w_state_d  = IsStore ? S_STORE : S_LOAD;
                end
            end
            S_LOAD, S_STORE: begin
                w_hold_d = r_acc_q;
                w_acc_d  = r_acc_q + r_stride_q;
                w_idx_d  = r_idx_q + 4'd1;
                if (r_idx_q == C_LAST_IDX) begin
                    w_state_d = (r_state_q == S_LOAD) ? S_DRAIN : S_FIN;
                end
            end
            S_DRAIN: begin
                // Elements return in issue order, so the last index marks the end.
                if (w_ret_vld && (w_ret_idx == C_LAST_IDX)) begin
                    w_state_d = S_FIN;
                end
            end
            S_FIN:   w_state_d = S_IDLE;
            default: w_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        w_pipe_vld_d    = r_pipe_vld_q;
        w_pipe_idx_d    = r_pipe_idx_q;
        w_pipe_vld_d[0] = (r_state_q == S_LOAD);
        w_pipe_idx_d[0] = r_idx_q;
        for (int k = 1; k < RD_LAT; k++) begin
            w_pipe_vld_d[k] = r_pipe_vld_q[k-1];
            w_pipe_idx_d[k] = r_pipe_idx_q[k-1];
        end
    end

    always_ff @(posedge Clk1) begin
        if (Reset) begin
            r_state_q    <= S_IDLE;
            r_acc_q      <= 16'd0;
            r_stride_q   <= 16'd0;
            r_idx_q      <= 4'd0;
            r_hold_q     <= 16'd0;
            r_pipe_vld_q <= '0;
            r_pipe_idx_q <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_acc_q      <= w_acc_d;
            r_stride_q   <= w_stride_d;
            r_idx_q      <= w_idx_d;
            r_hold_q     <= w_hold_d;
            r_pipe_vld_q <= w_pipe_vld_d;
            r_pipe_idx_q <= w_pipe_idx_d;
        end
    end

    always_comb begin
        RD        = (r_state_q == S_LOAD);
        WR        = (r_state_q == S_STORE);
        Addr      = w_issue ? r_acc_q : r_hold_q;
        VecIdx    = WR ? r_idx_q : 4'd0;
        DataOut   = WR ? VecRdData : 16'd0;
        VecWrEn   = w_ret_vld;
        VecWrIdx  = w_ret_vld ? w_ret_idx : 4'd0;
        VecWrData = w_ret_vld ? DataIn : 16'd0;
        Busy      = w_issue || (r_state_q == S_DRAIN);
        Done      = (r_state_q == S_FIN);
    end

endmodule
`default_nettype wire

// File: tb/tb_vec_mem_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vec_mem_seq
//  Description : Self-checking bench for vec_mem_seq. Two instances (read
//                latency 1 and 3) share the command inputs but have separate
//                Start strobes, memories and register files. A per-cycle
//                timeline model derived from the command parameters predicts
//                every strobe, address and data word.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_mem_seq;

    localparam int VLEN = 16;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start [2];
    logic        is_store;
    logic [15:0] base_in, stride_in;

    logic [15:0] addr_o [2], dout_o [2], data_in [2], vec_rd [2], wdata_o [2];
    logic [3:0]  vidx_o [2], widx_o [2];
    logic        rd_o [2], wr_o [2], we_o [2], busy_o [2], done_o [2];

    logic [15:0] mem [2][65536];
    logic [15:0] vrf [2][16];
    logic [15:0] rp  [2][4];

    generate
        for (genvar g = 0; g < 2; g++) begin : g_dut
            vec_mem_seq #(.VLEN(VLEN), .RD_LAT(g == 0 ? 1 : 3)) u_dut (
                .Clk1(clk), .Reset(rst), .Start(start[g]), .IsStore(is_store),
                .BaseAddr(base_in), .Stride(stride_in),
                .Addr(addr_o[g]), .RD(rd_o[g]), .WR(wr_o[g]), .DataOut(dout_o[g]),
                .DataIn(data_in[g]), .VecIdx(vidx_o[g]), .VecRdData(vec_rd[g]),
                .VecWrEn(we_o[g]), .VecWrIdx(widx_o[g]), .VecWrData(wdata_o[g]),
                .Busy(busy_o[g]), .Done(done_o[g])
            );
            assign vec_rd[g] = vrf[g][vidx_o[g]];
        end
    endgenerate

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model state per instance
    bit          act [2];
    int          t [2];
    bit          m_st [2];
    logic [15:0] m_base [2], m_stride [2], last_addr [2];
    int          done_seen [2], done_cyc [2], issue_cnt [2];
    logic [15:0] first_a [2], last_a [2];

    typedef struct {
        int          inst;
        bit          st;
        logic [15:0] base;
        logic [15:0] stride;
        logic [15:0] first;
        logic [15:0] last;
        int          done_c;
    } vec_t;
    vec_t tab [6];

    function automatic int lat(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic logic [15:0] addr_of(input logic [15:0] b, input logic [15:0] s, input int k);
        logic [15:0] kk;
        kk = 16'(k);
        return b + kk * s;
    endfunction

    task automatic chk(input string name, input int g, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s inst%0d cyc%0d: got %0h expected %0h", name, g, cyc, got, exp);
        end
    endtask

    task automatic check_cycle(input int g);
        int          last, k;
        bit          e_rd, e_wr, e_we, e_busy, e_done;
        logic [15:0] e_addr;
        last   = m_st[g] ? VLEN : VLEN + lat(g);
        e_busy = act[g] && (t[g] <= last);
        e_done = act[g] && (t[g] == last + 1);
        e_rd   = act[g] && !m_st[g] && (t[g] <= VLEN);
        e_wr   = act[g] &&  m_st[g] && (t[g] <= VLEN);
        e_we   = act[g] && !m_st[g] && (t[g] > lat(g)) && (t[g] <= VLEN + lat(g));
        e_addr = addr_of(m_base[g], m_stride[g], t[g] - 1);
        chk("busy", g, 32'(busy_o[g]), 32'(e_busy));
        chk("done", g, 32'(done_o[g]), 32'(e_done));
        chk("rd",   g, 32'(rd_o[g]),   32'(e_rd));
        chk("wr",   g, 32'(wr_o[g]),   32'(e_wr));
        chk("vecwren", g, 32'(we_o[g]), 32'(e_we));
        if (e_rd || e_wr) chk("addr", g, 32'(addr_o[g]), 32'(e_addr));
        if (!act[g])      chk("idle_addr", g, 32'(addr_o[g]), 32'(last_addr[g]));
        if (e_wr) begin
            chk("vecidx",  g, 32'(vidx_o[g]), 32'(t[g] - 1));
            chk("dataout", g, 32'(dout_o[g]), 32'(vrf[g][t[g] - 1]));
        end
        if (e_we) begin
            k = t[g] - lat(g) - 1;
            chk("vecwridx",  g, 32'(widx_o[g]),  32'(k));
            chk("vecwrdata", g, 32'(wdata_o[g]), 32'(mem[g][addr_of(m_base[g], m_stride[g], k)]));
        end
        // Memory / VRF side effects driven by the DUT's outputs
        if (wr_o[g]) mem[g][addr_o[g]] = dout_o[g];
        if (we_o[g]) vrf[g][widx_o[g]] = wdata_o[g];
        for (int j = 3; j > 0; j--) rp[g][j] = rp[g][j-1];
        rp[g][0] = rd_o[g] ? mem[g][addr_o[g]] : 16'hDEAD;
        if (e_rd || e_wr) last_addr[g] = e_addr;
        if (rd_o[g] || wr_o[g]) begin
            if (issue_cnt[g] == 0) first_a[g] = addr_o[g];
            last_a[g] = addr_o[g];
            issue_cnt[g]++;
        end
        if (done_o[g]) begin
            done_seen[g]++;
            done_cyc[g] = cyc;
        end
    endtask

    // One clock: model advances on the edge, inputs refresh just after it,
    // outputs are checked on the falling edge.
    task automatic step();
        for (int g = 0; g < 2; g++) begin
            if (rst) begin
                act[g] = 1'b0;
                last_addr[g] = 16'd0;
            end else if (act[g]) begin
                if (t[g] == (m_st[g] ? VLEN : VLEN + lat(g)) + 1) act[g] = 1'b0;
                else t[g]++;
            end else if (start[g]) begin
                act[g] = 1'b1; t[g] = 1; m_st[g] = is_store;
                m_base[g] = base_in; m_stride[g] = stride_in;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int g = 0; g < 2; g++) data_in[g] = rp[g][lat(g) - 1];
        @(negedge clk);
        for (int g = 0; g < 2; g++) check_cycle(g);
    endtask

    task automatic wait_done(input int g, input int n0, input int c0, output int dc);
        for (int n = 0; n < 40 && done_seen[g] == n0; n++) step();
        if (done_seen[g] == n0) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout inst%0d: got no Done expected Done within 40 cycles", g);
            dc = -1;
        end else begin
            dc = done_cyc[g] - c0;
        end
    endtask

    task automatic run_cmd(input int g, input bit st, input logic [15:0] b, input logic [15:0] s, output int dc);
        int c0, n0;
        issue_cnt[g] = 0;
        is_store = st; base_in = b; stride_in = s;
        start[g] = 1'b1;
        c0 = cyc; n0 = done_seen[g];
        step();
        start[g] = 1'b0;
        wait_done(g, n0, c0, dc);
        step();
    endtask

    task automatic init_vrf();
        for (int g = 0; g < 2; g++)
            for (int k = 0; k < 16; k++) vrf[g][k] = 16'h5500 + 16'(k);
    endtask

    initial begin
        int dc, c0, n0;
        logic [15:0] s;

        for (int g = 0; g < 2; g++) begin
            for (int a = 0; a < 65536; a++) mem[g][a] = 16'($urandom);
            for (int k = 0; k < 16; k++) mem[g][16'h0100 + k] = 16'hA000 + 16'(k);
            for (int j = 0; j < 4; j++) rp[g][j] = 16'h0;
            data_in[g] = 16'h0; start[g] = 1'b0;
            act[g] = 1'b0; t[g] = 0; m_st[g] = 1'b0; m_base[g] = 0; m_stride[g] = 0;
            last_addr[g] = 0; done_seen[g] = 0; done_cyc[g] = 0; issue_cnt[g] = 0;
            first_a[g] = 0; last_a[g] = 0;
        end
        init_vrf();
        is_store = 1'b0; base_in = 16'h0; stride_in = 16'h0;

        tab[0] = '{0, 1'b0, 16'h0100, 16'h0001, 16'h0100, 16'h010F, 18};
        tab[1] = '{0, 1'b1, 16'hFFFC, 16'h0002, 16'hFFFC, 16'h001A, 17};
        tab[2] = '{0, 1'b0, 16'h0040, 16'hFFFF, 16'h0040, 16'h0031, 18};
        tab[3] = '{0, 1'b1, 16'h0200, 16'h0000, 16'h0200, 16'h0200, 17};
        tab[4] = '{1, 1'b0, 16'h0100, 16'h0001, 16'h0100, 16'h010F, 20};
        tab[5] = '{1, 1'b1, 16'h3000, 16'h0010, 16'h3000, 16'h30F0, 17};

        // Reset state
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Directed command table
        for (int i = 0; i < 6; i++) begin
            init_vrf();
            run_cmd(tab[i].inst, tab[i].st, tab[i].base, tab[i].stride, dc);
            chk("tab_done_cycle", tab[i].inst, 32'(dc), 32'(tab[i].done_c));
            chk("tab_first_addr", tab[i].inst, 32'(first_a[tab[i].inst]), 32'(tab[i].first));
            chk("tab_last_addr",  tab[i].inst, 32'(last_a[tab[i].inst]),  32'(tab[i].last));
            chk("tab_issues",     tab[i].inst, 32'(issue_cnt[tab[i].inst]), 32'(VLEN));
        end
        chk("stride0_final", 0, 32'(mem[0][16'h0200]), 32'h550F);
        for (int k = 0; k < 16; k++)
            chk("wrap_readback", 0, 32'(mem[0][16'hFFFC + 16'(2 * k)]), 32'(16'h5500 + 16'(k)));

        // Reset in the middle of a store, after five writes
        init_vrf();
        is_store = 1'b1; base_in = 16'h0500; stride_in = 16'h0001;
        start[0] = 1'b1; n0 = done_seen[0]; issue_cnt[0] = 0;
        step();
        start[0] = 1'b0;
        repeat (4) step();
        chk("writes_before_reset", 0, 32'(issue_cnt[0]), 32'd5);
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        repeat (20) step();
        chk("no_done_after_abort", 0, 32'(done_seen[0] - n0), 32'd0);
        run_cmd(0, 1'b1, 16'h0600, 16'h0001, dc);
        chk("post_reset_done", 0, 32'(dc), 32'd17);

        // Start collisions: mid-load and in the FIN cycle
        init_vrf();
        is_store = 1'b0; base_in = 16'h0100; stride_in = 16'h0001;
        start[0] = 1'b1; c0 = cyc; n0 = done_seen[0];
        step();
        start[0] = 1'b0;
        while (cyc - c0 < 5) step();
        start[0] = 1'b1; base_in = 16'h0777; is_store = 1'b1;
        step();
        start[0] = 1'b0;
        wait_done(0, n0, c0, dc);
        chk("collision_load_done", 0, 32'(dc), 32'd18);
        start[0] = 1'b1; is_store = 1'b1; base_in = 16'h0900; stride_in = 16'h0003;
        step();
        c0 = cyc;
        step();
        start[0] = 1'b0;
        wait_done(0, n0 + 1, c0, dc);
        chk("collision_store_done", 0, 32'(dc), 32'd17);
        step();
        chk("collision_done_count", 0, 32'(done_seen[0] - n0), 32'd2);

        // Randomized commands
        for (int i = 0; i < 40; i++) begin
            int g;
            bit st;
            g  = int'($urandom_range(0, 1));
            st = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       s = 16'h0000;
                1:       s = 16'h0001;
                2:       s = 16'hFFFF;
                default: s = 16'($urandom);
            endcase
            for (int k = 0; k < 16; k++) vrf[g][k] = 16'($urandom);
            run_cmd(g, st, 16'($urandom), s, dc);
            chk("rand_done_cycle", g, 32'(dc), 32'(st ? VLEN + 1 : VLEN + lat(g) + 1));
            chk("rand_issues", g, 32'(issue_cnt[g]), 32'(VLEN));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
